// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
// Shared constants for the memory bus arbiter and the CPU pipeline:
//   - arb_state_t : arbiter state encoding (IDLE, GNT_IC, GNT_DC, GNT_DMA)
//   - SEL_*       : address/data mux select codes driven on mem_sel
//   - sel_for_state() : maps an arbiter state to its mem_sel code
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GNT_IC  = 2'b01,
    GNT_DC  = 2'b10,
    GNT_DMA = 2'b11
  } arb_state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_IC   = 2'b01;
  localparam logic [1:0] SEL_DC   = 2'b10;
  localparam logic [1:0] SEL_DMA  = 2'b11;

  function automatic logic [1:0] sel_for_state(input arb_state_t s);
    logic [1:0] sel;
    sel = SEL_NONE;
    case (s)
      GNT_IC:  sel = SEL_IC;
      GNT_DC:  sel = SEL_DC;
      GNT_DMA: sel = SEL_DMA;
      default: sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
// Request/grant bundle between the memory requesters (I-cache, D-cache, DMA,
// memory controller done pulse) and the memory bus arbiter.
//   ic_req, dc_req, dma_br, mem_done : requester side -> arbiter
//   ic_gnt, dc_gnt, dma_bg           : one-hot ownership grants
//   access_mem                       : CPU may use the bus (hazard unit stall input)
//   mem_sel[1:0]                     : address/data mux select
// Modports:
//   master : the requester side (drives requests, observes grants)
//   slave  : the arbiter (observes requests, drives grants)
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  logic       ic_req;
  logic       dc_req;
  logic       dma_br;
  logic       mem_done;
  logic       ic_gnt;
  logic       dc_gnt;
  logic       dma_bg;
  logic       access_mem;
  logic [1:0] mem_sel;

  modport master (
    output ic_req, dc_req, dma_br, mem_done,
    input  ic_gnt, dc_gnt, dma_bg, access_mem, mem_sel
  );

  modport slave (
    input  ic_req, dc_req, dma_br, mem_done,
    output ic_gnt, dc_gnt, dma_bg, access_mem, mem_sel
  );

endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Arbitrates the shared memory bus between I-cache, D-cache and DMA.
// Fixed priority dc_req > ic_req > dma_br; every grant is followed by at least
// one IDLE cycle for bus turnaround. CPU grants end on mem_done, the DMA grant
// ends when dma_br drops. All outputs are registered and decoded from the state.
//
// Ports:
//   clk      : clock, rising edge
//   reset_n  : synchronous active-low reset
//   bus      : mem_bus_arbiter_if.slave (requests in, grants/mux select out)
// Parameters:
//   AGE_LIMIT : DMA wait cycles before it is promoted to top priority
//   AGE_W     : width of the DMA age counter (AGE_LIMIT <= 2**AGE_W-1)
// Build option:
//   ARB_DMA_AGING_EN : when defined, a saturating DMA age counter promotes a
//                      starved DMA request to top priority in IDLE.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AGE_LIMIT = 8,
  parameter int AGE_W     = 4
) (
  input logic               clk,
  input logic               reset_n,
  mem_bus_arbiter_if.slave  bus
);

  arb_state_t state;
  arb_state_t next_state;
  logic       dma_aged;

`ifdef ARB_DMA_AGING_EN
  localparam logic [AGE_W-1:0] AGE_LIMIT_V = AGE_W'(AGE_LIMIT);

  logic [AGE_W-1:0] dma_age;

  assign dma_aged = (dma_age >= AGE_LIMIT_V);

  // Counts cycles DMA waits outside its grant; saturates so a long wait
  // cannot wrap back below the limit. Cleared when the DMA is granted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dma_age <= '0;
    end else if (next_state == GNT_DMA && state != GNT_DMA) begin
      dma_age <= '0;
    end else if (bus.dma_br && state != GNT_DMA && dma_age != '1) begin
      dma_age <= dma_age + AGE_W'(1);
    end
  end
`else
  assign dma_aged = 1'b0;
`endif

  // Grant decisions are only taken in IDLE; every grant state can only exit
  // to IDLE, which guarantees the turnaround cycle between owners.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.dma_br && dma_aged)  next_state = GNT_DMA;
        else if (bus.dc_req)         next_state = GNT_DC;
        else if (bus.ic_req)         next_state = GNT_IC;
        else if (bus.dma_br)         next_state = GNT_DMA;
        else                         next_state = IDLE;
      end
      GNT_IC, GNT_DC: begin
        if (bus.mem_done) next_state = IDLE;
      end
      GNT_DMA: begin
        if (!bus.dma_br) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered alongside the state by decoding next_state, so
  // they always reflect the state register without any combinational path
  // from the request inputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      bus.ic_gnt     <= 1'b0;
      bus.dc_gnt     <= 1'b0;
      bus.dma_bg     <= 1'b0;
      bus.access_mem <= 1'b1;
      bus.mem_sel    <= SEL_NONE;
    end else begin
      state          <= next_state;
      bus.ic_gnt     <= (next_state == GNT_IC);
      bus.dc_gnt     <= (next_state == GNT_DC);
      bus.dma_bg     <= (next_state == GNT_DMA);
      bus.access_mem <= (next_state != GNT_DMA);
      bus.mem_sel    <= sel_for_state(next_state);
    end
  end

endmodule
